shot_sequencer: RTL
===================

Name: shot_sequencer

Overview:
- Round controller for the shooting game.
- Accepts a fire press, pulses `shoot` into the target generator, and flies a projectile up the 32x32 grid one row per tick.
- Decides hit or miss against the live target coordinates, then pulses `result_valid` so a new target is drawn.
- Tracks score, shots remaining and game over; sits between the debounced buttons and the target generator and display logic.

Parameters:
- MAX_SHOTS, 8, shots per game (1..31).
- TICK_DIV, 4, clock cycles per projectile row step (>=1).
- SCORE_W, 8, score counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  level; starts or restarts a game
- fire  in  1  debounced fire button, level
- aim_x  in  5  shooter column, sampled on fire acceptance
- target_x  in  5  current target column from target generator
- target_y  in  5  current target row from target generator
- shoot  out  1  one-cycle pulse on shot launch
- result_valid  out  1  one-cycle pulse when shot resolves
- hit  out  1  result of last shot; valid from result_valid onward
- proj_x  out  5  projectile column
- proj_y  out  5  projectile row
- proj_active  out  1  high while projectile in flight
- score  out  SCORE_W  hits accumulated
- shots_left  out  5  remaining shots
- game_over  out  1  high in GAME_OVER state

Behaviour:
- Reset is asynchronous and active-high.
- Reset values:
  - state IDLE.
  - All pulses 0; hit 0.
  - proj_x and proj_y 0; proj_active 0.
  - score 0; shots_left MAX_SHOTS; game_over 0.
  - fire_q 0; tick counter 0.
- Fire edge: fire_q registers fire. fire_rise = fire & ~fire_q. Only rising edges are acted on; holding fire never re-fires.
- IDLE:
  - start=1 -> AIM next cycle.
  - score cleared, shots_left set to MAX_SHOTS.
- AIM:
  - fire_rise -> proj_x<=aim_x, proj_y<=0, tick counter<=0.
  - shoot=1 for exactly this one cycle; -> FLIGHT.
  - start is ignored in AIM.
- FLIGHT:
  - proj_active=1; tick counter counts 0..TICK_DIV-1.
  - On wrap, proj_y increments.
  - After each increment, compare registered proj_x/proj_y with target_x/target_y.
  - Hit when both are equal. Miss when proj_y==31 and not equal.
  - Either outcome -> RESULT.
  - target_x/target_y are stable during FLIGHT because no shoot or result_valid occurs.
  - fire_rise is ignored.
- RESULT (one cycle):
  - result_valid=1; hit registered.
  - shots_left decrements; score increments on hit, saturating at 2^SCORE_W-1.
  - shots_left reaching 0 -> GAME_OVER, else -> AIM.
  - proj_active=0.
- GAME_OVER:
  - game_over=1.
  - start=1 -> clear score, shots_left<=MAX_SHOTS -> AIM.
- Latency:
  - Fire press to shoot: 1 cycle after the rising edge is registered.
  - shoot to result_valid: TICK_DIV*(rows travelled)+1 cycles.
- Simultaneous events:
  - start and fire_rise in the same IDLE cycle -> only start is honoured.
  - Hit takes priority over the row-31 miss when the target is at row 31.
- Reset mid-flight: immediately returns to IDLE; no result_valid is emitted.

Optional Feature:
- Macro: SHOT_SEQUENCER_STREAK_BONUS_EN.
- With the macro defined:
  - A 2-bit saturating streak counter counts consecutive hits; a miss clears it.
  - When the prior streak is >=2, a hit adds 2 instead of 1, still saturating.
  - Streak clears on game start and on reset.
- Without the macro: every hit adds 1 and no streak logic exists.

Decomposition:
- Package game_pkg:
  - state enum {IDLE, AIM, FLIGHT, RESULT, GAME_OVER}.
  - COORD_W=5, GRID_MAX=31.
  - Shared with the target generator and display.
- Sub-module game_tick: TICK_DIV counter with clear and enable, outputs a one-cycle step pulse; instantiated once.

Test Plan:
1. Reset, start=1 -> AIM; shots_left=8, score=0, game_over=0; all pulses 0.
2. aim_x=5, target fixed (5,30), fire rise -> shoot one cycle; proj_y steps every 4 cycles; result_valid at proj_y=30; hit=1, score=1, shots_left=7.
3. aim_x=6, target (5,31) -> proj_y reaches 31, hit=0, score unchanged, shots_left decrements; fire held high across the whole shot causes no second shoot.
4. Eight shots -> GAME_OVER, game_over=1; further fire ignored; start -> AIM, shots_left=8, score=0.
5. Assert reset at proj_y=10 mid-flight -> outputs go to reset values immediately; no result_valid.
6. With SHOT_SEQUENCER_STREAK_BONUS_EN, three consecutive hits -> score 1,2,4; a miss then a hit -> +1.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game types: FSM state encoding and grid geometry for the shooter,
// target generator and display.
`default_nettype none

package game_pkg;

  localparam int COORD_W = 5;
  localparam logic [COORD_W-1:0] GRID_MAX = 5'd31;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    AIM       = 3'd1,
    FLIGHT    = 3'd2,
    RESULT    = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/game_tick.sv
// Projectile row-step divider: one-cycle step pulse every TICK_DIV enabled cycles.
`default_nettype none

module game_tick #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic step_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign step_o = en_i && (cnt_q == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/shot_sequencer.sv
// Shooting-game round controller: fire edge -> projectile flight -> hit/miss, score and shots.
// Optional streak bonus scoring enabled by SHOT_SEQUENCER_STREAK_BONUS_EN.
`default_nettype none

module shot_sequencer
  import game_pkg::*;
#(
  parameter int MAX_SHOTS = 8,
  parameter int TICK_DIV  = 4,
  parameter int SCORE_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 fire,
  input  logic [COORD_W-1:0]   aim_x,
  input  logic [COORD_W-1:0]   target_x,
  input  logic [COORD_W-1:0]   target_y,
  output logic                 shoot,
  output logic                 result_valid,
  output logic                 hit,
  output logic [COORD_W-1:0]   proj_x,
  output logic [COORD_W-1:0]   proj_y,
  output logic                 proj_active,
  output logic [SCORE_W-1:0]   score,
  output logic [COORD_W-1:0]   shots_left,
  output logic                 game_over
);

  localparam logic [COORD_W-1:0] SHOTS_INIT = COORD_W'(MAX_SHOTS);

  state_t               state_q, state_d;
  logic                 fire_q;
  logic                 shoot_q, shoot_d;
  logic                 result_valid_q, result_valid_d;
  logic                 hit_q, hit_d;
  logic [COORD_W-1:0]   proj_x_q, proj_x_d;
  logic [COORD_W-1:0]   proj_y_q, proj_y_d;
  logic                 proj_active_q, proj_active_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [COORD_W-1:0]   shots_left_q, shots_left_d;
  logic                 game_over_q, game_over_d;
  logic                 stepped_q, stepped_d;
`ifdef SHOT_SEQUENCER_STREAK_BONUS_EN
  logic [1:0]           streak_q, streak_d;
`endif

  logic                 fire_rise;
  logic                 launch;
  logic                 step;
  logic                 on_target;
  logic                 resolve;
  logic [1:0]           score_inc;
  logic [SCORE_W:0]     score_sum;
  logic [SCORE_W-1:0]   score_sat;

  assign fire_rise = fire & ~fire_q;
  assign launch    = (state_q == AIM) && fire_rise;
  assign on_target = (proj_x_q == target_x) && (proj_y_q == target_y);
  // Resolve only on the cycle right after a row step, so the compare sees the new row.
  assign resolve   = (state_q == FLIGHT) && stepped_q &&
                     (on_target || (proj_y_q == GRID_MAX));

`ifdef SHOT_SEQUENCER_STREAK_BONUS_EN
  assign score_inc = (streak_q >= 2'd2) ? 2'd2 : 2'd1;
`else
  assign score_inc = 2'd1;
`endif
  assign score_sum = {1'b0, score_q} + (SCORE_W+1)'(score_inc);
  assign score_sat = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

  game_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .clear_i (launch),
    .en_i    (state_q == FLIGHT),
    .step_o  (step)
  );

  always_comb begin
    state_d        = state_q;
    shoot_d        = 1'b0;
    result_valid_d = 1'b0;
    hit_d          = hit_q;
    proj_x_d       = proj_x_q;
    proj_y_d       = proj_y_q;
    proj_active_d  = proj_active_q;
    score_d        = score_q;
    shots_left_d   = shots_left_q;
    game_over_d    = game_over_q;
    stepped_d      = 1'b0;
`ifdef SHOT_SEQUENCER_STREAK_BONUS_EN
    streak_d       = streak_q;
`endif

    case (state_q)
      IDLE, GAME_OVER: begin
        if (start) begin
          state_d      = AIM;
          game_over_d  = 1'b0;
          score_d      = '0;
          shots_left_d = SHOTS_INIT;
`ifdef SHOT_SEQUENCER_STREAK_BONUS_EN
          streak_d     = 2'd0;
`endif
        end
      end
      AIM: begin
        if (launch) begin
          state_d       = FLIGHT;
          shoot_d       = 1'b1;
          proj_x_d      = aim_x;
          proj_y_d      = '0;
          proj_active_d = 1'b1;
        end
      end
      FLIGHT: begin
        if (resolve) begin
          state_d        = RESULT;
          result_valid_d = 1'b1;
          hit_d          = on_target;
          proj_active_d  = 1'b0;
          shots_left_d   = shots_left_q - COORD_W'(1);
          if (on_target) begin
            score_d = score_sat;
          end
`ifdef SHOT_SEQUENCER_STREAK_BONUS_EN
          if (on_target) begin
            streak_d = (streak_q == 2'd3) ? 2'd3 : streak_q + 2'd1;
          end else begin
            streak_d = 2'd0;
          end
`endif
        end else if (step) begin
          proj_y_d  = proj_y_q + COORD_W'(1);
          stepped_d = 1'b1;
        end
      end
      RESULT: begin
        if (shots_left_q == '0) begin
          state_d     = GAME_OVER;
          game_over_d = 1'b1;
        end else begin
          state_d = AIM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      fire_q         <= 1'b0;
      shoot_q        <= 1'b0;
      result_valid_q <= 1'b0;
      hit_q          <= 1'b0;
      proj_x_q       <= '0;
      proj_y_q       <= '0;
      proj_active_q  <= 1'b0;
      score_q        <= '0;
      shots_left_q   <= SHOTS_INIT;
      game_over_q    <= 1'b0;
      stepped_q      <= 1'b0;
`ifdef SHOT_SEQUENCER_STREAK_BONUS_EN
      streak_q       <= 2'd0;
`endif
    end else begin
      state_q        <= state_d;
      fire_q         <= fire;
      shoot_q        <= shoot_d;
      result_valid_q <= result_valid_d;
      hit_q          <= hit_d;
      proj_x_q       <= proj_x_d;
      proj_y_q       <= proj_y_d;
      proj_active_q  <= proj_active_d;
      score_q        <= score_d;
      shots_left_q   <= shots_left_d;
      game_over_q    <= game_over_d;
      stepped_q      <= stepped_d;
`ifdef SHOT_SEQUENCER_STREAK_BONUS_EN
      streak_q       <= streak_d;
`endif
    end
  end

  assign shoot        = shoot_q;
  assign result_valid = result_valid_q;
  assign hit          = hit_q;
  assign proj_x       = proj_x_q;
  assign proj_y       = proj_y_q;
  assign proj_active  = proj_active_q;
  assign score        = score_q;
  assign shots_left   = shots_left_q;
  assign game_over    = game_over_q;

endmodule

`default_nettype wire
